channel_adder_tree_framed: RTL and testbench

Digit-serial, multi-channel adder tree that sums INPUT_NUM channels presented LSB-digit first, DIGIT_W bits per cycle, with explicit word framing. It adds what the plain carry-save tree lacks: an unsigned/signed mode, automatic carry-growth flush digits so every output word is complete, a ready handshake, and first/last markers on the output. It sits between the per-channel MAC digit streams and the NPU output accumulator.

---
 rtl/channel_adder_tree_framed.sv | 202 ++++++++++++++++++++
 tb/tb_channel_adder_tree_framed.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_adder_tree_framed.sv
// Digit-serial multi-channel adder tree with word framing: LSB-first digits in,
// flush digits appended per word so carry growth always reaches the output.
module channel_adder_tree_framed #(
  parameter int INPUT_NUM = 8,
  parameter int DIGIT_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         signed_mode,
  input  logic                         din_vld,
  output logic                         din_rdy,
  input  logic                         din_first,
  input  logic                         din_last,
  input  logic [INPUT_NUM*DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0]           dout,
  output logic                         dout_vld,
  output logic                         dout_first,
  output logic                         dout_last
);

  localparam int STAGE      = $clog2(INPUT_NUM);
  localparam int PAD        = 1 << STAGE;
  localparam int EXT_DIGITS = (STAGE + DIGIT_W - 1) / DIGIT_W;
  localparam int CNT_W      = (EXT_DIGITS > 1) ? $clog2(EXT_DIGITS) : 1;
  localparam int NODE_N     = 2 * PAD - 1;

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_flush;
  logic               w_flush_last;
  logic               r_signed;
  logic [INPUT_NUM-1:0] r_msb;

  logic [PAD*DIGIT_W-1:0]    w_leaf;
  // Heap-ordered node bus: node i lives at slice i-1, children of i are 2i and 2i+1.
  logic [NODE_N*DIGIT_W-1:0] w_node;
  logic [STAGE:0]            w_vld;
  logic [STAGE:0]            w_fst;
  logic [STAGE:0]            w_lst;
  logic [STAGE:1]            r_vld;
  logic [STAGE:1]            r_fst;
  logic [STAGE:1]            r_lst;

  logic [DIGIT_W-1:0] r_dout;
  logic               r_dout_vld;
  logic               r_dout_first;
  logic               r_dout_last;

  assign w_accept = din_vld & din_rdy;

  // FSM state and flush counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCEPT;
      r_cnt   <= '0;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ACCEPT: begin
        if (w_accept && din_last) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_W'(EXT_DIGITS - 1);
        end else begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_ACCEPT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_ACCEPT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    din_rdy      = 1'b0;
    w_flush      = 1'b0;
    w_flush_last = 1'b0;
    case (r_state)
      ST_ACCEPT: din_rdy = clk_en;
      ST_FLUSH: begin
        w_flush      = 1'b1;
        w_flush_last = (r_cnt == '0);
      end
      default: din_rdy = 1'b0;
    endcase
  end

  // Word mode and per-channel sign capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
      r_msb    <= '0;
    end else if (w_accept) begin
      if (din_first) r_signed <= signed_mode;
      if (din_last) begin
        for (int c = 0; c < INPUT_NUM; c++) begin
          r_msb[c] <= din[c*DIGIT_W + DIGIT_W - 1];
        end
      end
    end
  end

  // Stage-0 leaves: live digits, or sign/zero extension while flushing
  always_comb begin
    w_leaf = '0;
    for (int c = 0; c < INPUT_NUM; c++) begin
      if (w_flush) begin
        w_leaf[c*DIGIT_W +: DIGIT_W] = {DIGIT_W{r_signed & r_msb[c]}};
      end else begin
        w_leaf[c*DIGIT_W +: DIGIT_W] = din[c*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_node[NODE_N*DIGIT_W-1 -: PAD*DIGIT_W] = w_leaf;
  assign w_vld = {r_vld, w_accept | w_flush};
  assign w_fst = {r_fst, w_accept & din_first};
  assign w_lst = {r_lst, w_flush & w_flush_last};

  // Framing pipeline, one register per stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_fst <= '0;
      r_lst <= '0;
    end else if (clk_en) begin
      r_vld <= w_vld[STAGE-1:0];
      r_fst <= w_fst[STAGE-1:0];
      r_lst <= w_lst[STAGE-1:0];
    end
  end

  for (genvar i = 1; i < PAD; i++) begin : g_node
    localparam int UP = STAGE - $clog2(i + 1);
    logic [DIGIT_W-1:0] r_sum;
    logic               r_cy;
    logic [DIGIT_W:0]   w_add;

    // A word's first digit starts with a clear carry, so words never bleed into each other.
    assign w_add = {1'b0, w_node[(2*i-1)*DIGIT_W +: DIGIT_W]}
                 + {1'b0, w_node[(2*i)*DIGIT_W +: DIGIT_W]}
                 + {{DIGIT_W{1'b0}}, r_cy & ~w_fst[UP]};

    // Serial adder node
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_cy  <= 1'b0;
      end else if (clk_en && w_vld[UP]) begin
        {r_cy, r_sum} <= w_add;
      end
    end

    assign w_node[(i-1)*DIGIT_W +: DIGIT_W] = r_sum;
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_dout_first <= 1'b0;
      r_dout_last  <= 1'b0;
    end else if (clk_en) begin
      r_dout_vld   <= w_vld[STAGE];
      r_dout_first <= w_vld[STAGE] & w_fst[STAGE];
      r_dout_last  <= w_vld[STAGE] & w_lst[STAGE];
      if (w_vld[STAGE]) r_dout <= w_node[DIGIT_W-1:0];
    end
  end

  assign dout       = r_dout;
  assign dout_vld   = r_dout_vld;
  assign dout_first = r_dout_first;
  assign dout_last  = r_dout_last;

endmodule

// File: tb/tb_channel_adder_tree_framed.sv
// Directed bench: an 8-channel and a 5-channel instance share one stimulus stream;
// output digits are collected per enabled edge and compared with hand-computed sums.
module tb_channel_adder_tree_framed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        signed_mode = 1'b0;
  logic        din_vld = 1'b0;
  logic        din_first = 1'b0;
  logic        din_last = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        din_rdy, dout_vld, dout_first, dout_last;
  logic [1:0]  dout;
  logic        din_rdy5, dout_vld5, dout_first5, dout_last5;
  logic [1:0]  dout5;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_cyc = 0;
  int   a_acc = 0;
  bit   en_rand = 1'b0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int         qa_cyc[$];

  always #5 clk = ~clk;

  channel_adder_tree_framed #(.INPUT_NUM(8), .DIGIT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .signed_mode(signed_mode),
    .din_vld(din_vld), .din_rdy(din_rdy), .din_first(din_first), .din_last(din_last),
    .din(din), .dout(dout), .dout_vld(dout_vld), .dout_first(dout_first), .dout_last(dout_last)
  );

  channel_adder_tree_framed #(.INPUT_NUM(5), .DIGIT_W(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .signed_mode(signed_mode),
    .din_vld(din_vld), .din_rdy(din_rdy5), .din_first(din_first), .din_last(din_last),
    .din(din[9:0]), .dout(dout5), .dout_vld(dout_vld5), .dout_first(dout_first5),
    .dout_last(dout_last5)
  );

  // Record {first,last,digit} once per enabled edge
  initial begin : collect
    bit en_s;
    forever begin
      @(posedge clk);
      cyc++;
      en_s = clk_en;
      #1;
      if (en_s && rst_n) begin
        if (dout_vld) begin
          qa.push_back({dout_first, dout_last, dout});
          qa_cyc.push_back(cyc);
        end
        if (dout_vld5) qb.push_back({dout_first5, dout_last5, dout5});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    clk_en = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [15:0] d, input logic f, input logic l);
    int t;
    t = 0;
    step();
    din = d; din_first = f; din_last = l; din_vld = 1'b1;
    #1;
    while (!din_rdy && t < 100) begin
      step();
      #1;
      t++;
    end
    if (t >= 100) check("send_timeout", {3'b000, din_rdy}, 4'b0001);
    @(posedge clk);
    #2;
    acc_cyc = cyc;
    din_vld = 1'b0; din_first = 1'b0; din_last = 1'b0;
  endtask

  // Expected word given as its value: digit j = expv[2j+1:2j]
  task automatic chk_word(input string tag, input bit inst5, input int n, input logic [15:0] expv);
    int t;
    int c;
    logic [3:0] o;
    t = 0;
    while (((inst5 ? qb.size() : qa.size()) < n) && t < 200) begin
      step();
      t++;
    end
    check({tag, "_len"}, {3'b000, ((inst5 ? qb.size() : qa.size()) >= n)}, 4'b0001);
    for (int j = 0; j < n; j++) begin
      if (!inst5 && qa.size() > 0) begin
        o = qa.pop_front();
        c = qa_cyc.pop_front();
        if (j == 0) first_cyc = c;
      end else if (inst5 && qb.size() > 0) begin
        o = qb.pop_front();
      end else begin
        o = 4'bxxxx;
      end
      check($sformatf("%s_d%0d", tag, j), o, {(j == 0), (j == n - 1), expv[2*j +: 2]});
    end
  endtask

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out", {dout_first, dout_last, dout}, 4'b0000);
    check("rst_vld", {3'b000, dout_vld}, 4'b0000);
    check("rst_rdy", {3'b000, din_rdy}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned single digit, all channels 3: 24 (8 ch), 15 (5 ch)
    send(16'hFFFF, 1'b1, 1'b1);
    a_acc = acc_cyc;
    step(); #1; check("u1_rdy0", {3'b000, din_rdy}, 4'b0000);
    step(); #1; check("u1_rdy1", {3'b000, din_rdy}, 4'b0000);
    step(); #1; check("u1_rdy2", {3'b000, din_rdy}, 4'b0001);
    chk_word("u1", 1'b0, 3, 16'h0018);
    check("u1_lat", 4'(first_cyc - a_acc), 4'd3);
    chk_word("u1_n5", 1'b1, 3, 16'h000F);

    // Signed single digit, all channels -1: -8 and -5 in 6 bits
    signed_mode = 1'b1;
    send(16'hFFFF, 1'b1, 1'b1);
    signed_mode = 1'b0;
    chk_word("s1", 1'b0, 3, 16'h0038);
    chk_word("s1_n5", 1'b1, 3, 16'h003B);

    // Two-digit words back to back: channel c = c, then all 15
    send(16'hE4E4, 1'b1, 1'b0);
    send(16'h5500, 1'b0, 1'b1);
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1);
    chk_word("w28", 1'b0, 4, 16'h001C);
    chk_word("w120", 1'b0, 4, 16'h0078);
    chk_word("w10_n5", 1'b1, 4, 16'h000A);
    chk_word("w75_n5", 1'b1, 4, 16'h004B);

    // Same words under random stalls and input gaps
    en_rand = 1'b1;
    send(16'hE4E4, 1'b1, 1'b0);
    idle(3);
    send(16'h5500, 1'b0, 1'b1);
    send(16'hFFFF, 1'b1, 1'b0);
    idle(2);
    send(16'hFFFF, 1'b0, 1'b1);
    chk_word("r28", 1'b0, 4, 16'h001C);
    chk_word("r120", 1'b0, 4, 16'h0078);
    chk_word("r10_n5", 1'b1, 4, 16'h000A);
    chk_word("r75_n5", 1'b1, 4, 16'h004B);
    en_rand = 1'b0;
    idle(8);
    check("r_no_extra", 4'(qa.size()), 4'd0);
    check("r_no_extra_n5", 4'(qb.size()), 4'd0);

    // Reset in mid-flush while a previous word is still emerging
    send(16'hFFFF, 1'b1, 1'b1);
    send(16'h0001, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check("mr_out", {dout_first, dout_last, dout}, 4'b0000);
    check("mr_vld", {3'b000, dout_vld}, 4'b0000);
    check("mr_out_n5", {dout_first5, dout_last5, dout5}, 4'b0000);
    step();
    rst_n = 1'b1;
    qa.delete(); qb.delete(); qa_cyc.delete();
    #1;
    check("mr_rdy", {3'b000, din_rdy}, 4'b0001);
    idle(8);
    check("mr_discard", 4'(qa.size()), 4'd0);
    check("mr_discard_n5", 4'(qb.size()), 4'd0);
    send(16'hFFFF, 1'b1, 1'b1);
    chk_word("mr_u1", 1'b0, 3, 16'h0018);
    chk_word("mr_u1_n5", 1'b1, 3, 16'h000F);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
